// File: rtl/layer_comp_pkg.sv
// Shared types and defaults for the layer priority compositor.
package layer_comp_pkg;

  localparam int unsigned MAX_LAYERS = 16;

  // Index width for a layer count; never narrower than one bit.
  function automatic int unsigned layer_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned LAYER_IDX_W = layer_idx_w(MAX_LAYERS);

  typedef logic [LAYER_IDX_W-1:0] layer_idx_t;
  typedef layer_idx_t prio_table_t [MAX_LAYERS];

  localparam logic [7:0] DEFAULT_TRANSPARENT = 8'hFF;
  localparam logic [7:0] DEFAULT_BACKGROUND  = 8'h00;

endpackage

// File: rtl/layer_blink_timer.sv
// Frame counter and blink phase; phase toggles every BLINK_FRAMES startOfFrame pulses.
// Instantiated only when LAYER_BLINK_EN is defined.
module layer_blink_timer #(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic resetN,
  input  logic sof,
  output logic phase
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] frame_cnt;

  // Phase starts at 0 so blinking layers are visible first.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (sof) begin
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/layer_priority_compositor.sv
// N-layer pixel compositor: 2-stage pipeline, programmable frame-synchronous priority table.
// Optional layer blinking is enabled by defining LAYER_BLINK_EN.
module layer_priority_compositor
  import layer_comp_pkg::*;
#(
  parameter int unsigned       NUM_LAYERS   = 8,
  parameter int unsigned       RGB_W        = 8,
  parameter logic [RGB_W-1:0]  TRANSPARENT  = RGB_W'(DEFAULT_TRANSPARENT),
  parameter logic [RGB_W-1:0]  BACKGROUND   = RGB_W'(DEFAULT_BACKGROUND),
  parameter int unsigned       BLINK_FRAMES = 30,
  localparam int unsigned      IDX_W        = layer_idx_w(NUM_LAYERS)
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS-1:0]       layerRequest,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [NUM_LAYERS-1:0]       enableMask,
  input  logic                        prioWrEn,
  input  logic [IDX_W-1:0]            prioWrSlot,
  input  logic [IDX_W-1:0]            prioWrLayer,
`ifdef LAYER_BLINK_EN
  input  logic [NUM_LAYERS-1:0]       blinkMask,
`endif
  output logic                        outRequest,
  output logic [RGB_W-1:0]            outRGB,
  output logic [IDX_W-1:0]            outLayer
);

  typedef logic [IDX_W-1:0] idx_t;

  idx_t                  shadow_tbl [NUM_LAYERS];
  idx_t                  active_tbl [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] blink_hide;
  logic [NUM_LAYERS-1:0] eff_c;
  logic [NUM_LAYERS-1:0] s1_eff;
  logic [RGB_W-1:0]      s1_rgb [NUM_LAYERS];
  logic                  win_found_c;
  idx_t                  win_idx_c;
  logic [RGB_W-1:0]      win_rgb_c;
  logic                  wr_ok_c;

`ifdef LAYER_BLINK_EN
  logic blink_phase;

  layer_blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_timer (
    .clk   (clk),
    .resetN(resetN),
    .sof   (startOfFrame),
    .phase (blink_phase)
  );

  assign blink_hide = blinkMask & {NUM_LAYERS{blink_phase}};
`else
  assign blink_hide = '0;
`endif

  assign wr_ok_c = prioWrEn
                 && (32'(prioWrSlot)  < NUM_LAYERS)
                 && (32'(prioWrLayer) < NUM_LAYERS);

  // Shadow takes writes; active copies the pre-edge shadow, so a same-cycle write waits a frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        shadow_tbl[i] <= IDX_W'(i);
        active_tbl[i] <= IDX_W'(i);
      end
    end else begin
      if (wr_ok_c) begin
        shadow_tbl[prioWrSlot] <= prioWrLayer;
      end
      if (startOfFrame) begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
          active_tbl[i] <= shadow_tbl[i];
        end
      end
    end
  end

  // Per-layer effective request.
  always_comb begin
    eff_c = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      eff_c[i] = layerRequest[i] & enableMask[i] & ~blink_hide[i]
               & (layerRGB[i*RGB_W +: RGB_W] != TRANSPARENT);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_eff <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        s1_rgb[i] <= '0;
      end
    end else begin
      s1_eff <= eff_c;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        s1_rgb[i] <= layerRGB[i*RGB_W +: RGB_W];
      end
    end
  end

  // First slot of the active table whose layer is requesting wins.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    win_rgb_c   = BACKGROUND;
    for (int s = 0; s < NUM_LAYERS; s++) begin
      if (!win_found_c && s1_eff[active_tbl[s]]) begin
        win_found_c = 1'b1;
        win_idx_c   = active_tbl[s];
        win_rgb_c   = s1_rgb[active_tbl[s]];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      outRequest <= 1'b0;
      outRGB     <= BACKGROUND;
      outLayer   <= '0;
    end else begin
      outRequest <= win_found_c;
      outRGB     <= win_rgb_c;
      outLayer   <= win_idx_c;
    end
  end

endmodule

// File: tb/tb_layer_priority_compositor.sv
// Directed self-checking bench for layer_priority_compositor (6 layers, so an out-of-range
// layer/slot index is representable on the 3-bit write ports).
module tb_layer_priority_compositor;

  localparam int unsigned NL = 6;
  localparam int unsigned RW = 8;
  localparam int unsigned IW = 3;

  logic             clk;
  logic             resetN;
  logic             startOfFrame;
  logic [NL-1:0]    layerRequest;
  logic [NL*RW-1:0] layerRGB;
  logic [NL-1:0]    enableMask;
  logic             prioWrEn;
  logic [IW-1:0]    prioWrSlot;
  logic [IW-1:0]    prioWrLayer;
  logic             outRequest;
  logic [RW-1:0]    outRGB;
  logic [IW-1:0]    outLayer;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [11:0] obs;
  logic [11:0] exp_v;

  layer_priority_compositor #(
    .NUM_LAYERS(NL),
    .RGB_W     (RW)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .layerRequest(layerRequest),
    .layerRGB    (layerRGB),
    .enableMask  (enableMask),
    .prioWrEn    (prioWrEn),
    .prioWrSlot  (prioWrSlot),
    .prioWrLayer (prioWrLayer),
`ifdef LAYER_BLINK_EN
    .blinkMask   ('0),
`endif
    .outRequest  (outRequest),
    .outRGB      (outRGB),
    .outLayer    (outLayer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {outRequest, outRGB, outLayer};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input logic [NL-1:0] req, input logic [7:0] r0, input logic [7:0] r1,
                        input logic [7:0] r2, input logic [7:0] r3, input logic [7:0] r4,
                        input logic [7:0] r5);
    layerRequest = req;
    layerRGB     = {r5, r4, r3, r2, r1, r0};
  endtask

  task automatic prio_write(input logic [IW-1:0] slot, input logic [IW-1:0] layer,
                            input logic sof);
    prioWrEn     = 1'b1;
    prioWrSlot   = slot;
    prioWrLayer  = layer;
    startOfFrame = sof;
    tick();
    prioWrEn     = 1'b0;
    startOfFrame = 1'b0;
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    startOfFrame = 1'b0;
    prioWrEn = 1'b0;
    prioWrSlot = '0;
    prioWrLayer = '0;
    enableMask = '1;
    set_px('0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    exp_v = {1'b0, 8'h00, 3'd0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL reset_values got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    set_px(6'b001001, 8'h1C, 8'h00, 8'h00, 8'hE0, 8'h00, 8'h00);
    tick();
    exp_v = {1'b0, 8'h00, 3'd0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL basic_latency1 got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    tick();
    exp_v = {1'b1, 8'h1C, 3'd0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL basic_latency2 got=%h want=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_reorder();
    prio_write(3'd0, 3'd3, 1'b0);
    tick();
    tick();
    exp_v = {1'b1, 8'h1C, 3'd0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL reorder_before_sof got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    sof_pulse();
    tick();
    tick();
    exp_v = {1'b1, 8'hE0, 3'd3};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL reorder_after_sof got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    // Layer 0 is now absent from the table.
    set_px(6'b000001, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    exp_v = {1'b0, 8'h00, 3'd0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL absent_layer got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    prio_write(3'd0, 3'd0, 1'b0);
    sof_pulse();
    tick();
    tick();
    exp_v = {1'b1, 8'h1C, 3'd0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL restore_identity got=%h want=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_transparent();
    set_px(6'b000100, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    exp_v = {1'b0, 8'h00, 3'd0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL transparent_key got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    set_px(6'b000100, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    exp_v = {1'b1, 8'h03, 3'd2};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL opaque_layer2 got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    enableMask = 6'b111011;
    tick();
    tick();
    exp_v = {1'b0, 8'h00, 3'd0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL disabled_layer got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    enableMask = '1;
  endtask

  task automatic test_sof_write();
    set_px(6'b010010, 8'h00, 8'h11, 8'h00, 8'h00, 8'h44, 8'h00);
    prio_write(3'd0, 3'd4, 1'b1);
    tick();
    tick();
    exp_v = {1'b1, 8'h11, 3'd1};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL same_cycle_write got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    sof_pulse();
    tick();
    tick();
    exp_v = {1'b1, 8'h44, 3'd4};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL next_frame_write got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    prio_write(3'd0, 3'd6, 1'b0);
    sof_pulse();
    tick();
    tick();
    total_cnt++;
    if (obs !== exp_v) $display("FAIL bad_layer_ignored got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    prio_write(3'd6, 3'd1, 1'b0);
    prio_write(3'd7, 3'd1, 1'b0);
    sof_pulse();
    tick();
    tick();
    total_cnt++;
    if (obs !== exp_v) $display("FAIL bad_slot_ignored got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    prio_write(3'd0, 3'd0, 1'b0);
    sof_pulse();
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_q [8];
    for (int k = 0; k < 8; k++) begin
      if (k == 5) begin
        exp_q[k] = {1'b0, 8'h00, 3'd0};
      end else if (k % 2 == 0) begin
        exp_q[k] = {1'b1, 8'(8'h20 + k), 3'd0};
      end else begin
        exp_q[k] = {1'b1, 8'(8'h50 + k), 3'd5};
      end
    end
    for (int k = 0; k < 9; k++) begin
      if (k == 5) begin
        set_px(6'b000000, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55);
      end else if (k < 8 && k % 2 == 0) begin
        set_px(6'b100001, 8'(8'h20 + k), 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
      end else if (k < 8) begin
        set_px(6'b100001, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'(8'h50 + k));
      end
      tick();
      if (k >= 1) begin
        total_cnt++;
        if (obs !== exp_q[k-1]) $display("FAIL stream_px%0d got=%h want=%h", k-1, obs, exp_q[k-1]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    set_px(6'b100101, 8'h1C, 8'h00, 8'h2A, 8'h00, 8'h00, 8'h55);
    prio_write(3'd0, 3'd5, 1'b0);
    sof_pulse();
    prio_write(3'd0, 3'd2, 1'b0);
    tick();
    tick();
    exp_v = {1'b1, 8'h55, 3'd5};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL pre_reset_order got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    #2 resetN = 1'b0;
    #1;
    exp_v = {1'b0, 8'h00, 3'd0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL async_reset got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    set_px('0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    resetN = 1'b1;
    sof_pulse();
    set_px(6'b100101, 8'h1C, 8'h00, 8'h2A, 8'h00, 8'h00, 8'h55);
    tick();
    exp_v = {1'b0, 8'h00, 3'd0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL post_reset_lat1 got=%h want=%h", obs, exp_v);
    else pass_cnt++;
    tick();
    exp_v = {1'b1, 8'h1C, 3'd0};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL post_reset_identity got=%h want=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reorder();
    test_transparent();
    test_sof_write();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
